uart_rx: RTL and testbench

UART receiver that deserialises an asynchronous serial line into bytes using 16x oversampling. It sits between the external RX pin and the byte-level consumer. Bit timing comes from a shared baud generator's `tick_16x` strobe. Each received frame is delivered with a single-cycle `data_ready` strobe plus per-frame parity and framing status.

---
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: 1 start, 8 data LSB first, optional even parity, 1 stop.
// Reports each frame with a one-cycle data_ready strobe plus parity and framing status.
module uart_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_16x,
  input  logic       rx_pin,
  input  logic       parity_enable,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       parity_err,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } state_t;

  // Nonzero when data plus parity bit hold an odd number of ones.
  function automatic logic even_parity_err(input logic [7:0] data, input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

  logic       sync1_r;
  logic       rx_s;
  state_t     state_r;
  logic [3:0] tick_cnt_r;
  logic [2:0] bit_idx_r;
  logic [7:0] shift_r;
  logic       par_en_r;
  logic       par_err_r;

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx_pin;
      rx_s    <= sync1_r;
    end
  end

  // Frame FSM with registered outputs; all state moves are gated by tick_16x.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      par_en_r   <= 1'b0;
      par_err_r  <= 1'b0;
      rx_data    <= 8'h00;
      data_ready <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      if (tick_16x) begin
        case (state_r)
          ST_IDLE: begin
            if (!rx_s) begin
              tick_cnt_r <= 4'd0;
              state_r    <= ST_START;
            end
          end
          ST_START: begin
            // Mid start bit: a high line here was only a glitch.
            if (tick_cnt_r == 4'd7) begin
              if (rx_s) begin
                state_r <= ST_IDLE;
              end else begin
                tick_cnt_r <= 4'd0;
                bit_idx_r  <= 3'd0;
                par_en_r   <= parity_enable;
                par_err_r  <= 1'b0;
                state_r    <= ST_DATA;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 4'd1;
            end
          end
          ST_DATA: begin
            tick_cnt_r <= tick_cnt_r + 4'd1;
            if (tick_cnt_r == 4'd15) begin
              shift_r[bit_idx_r] <= rx_s;
              bit_idx_r          <= bit_idx_r + 3'd1;
              if (bit_idx_r == 3'd7) begin
                state_r <= par_en_r ? ST_PARITY : ST_STOP;
              end
            end
          end
          ST_PARITY: begin
            tick_cnt_r <= tick_cnt_r + 4'd1;
            if (tick_cnt_r == 4'd15) begin
              par_err_r <= even_parity_err(shift_r, rx_s);
              state_r   <= ST_STOP;
            end
          end
          ST_STOP: begin
            tick_cnt_r <= tick_cnt_r + 4'd1;
            if (tick_cnt_r == 4'd15) begin
              rx_data    <= shift_r;
              parity_err <= par_en_r & par_err_r;
              frame_err  <= ~rx_s;
              data_ready <= 1'b1;
              state_r    <= rx_s ? ST_IDLE : ST_BREAK_WAIT;
            end
          end
          ST_BREAK_WAIT: begin
            // A line held low after a bad stop must not look like a new start.
            if (rx_s) begin
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: frames are modelled at byte level and
// compared by an independent monitor whenever data_ready pulses.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       reset;
  logic       tick_16x;
  logic       rx_pin;
  logic       parity_enable;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_data;

  uart_rx dut (
    .clk          (clk),
    .reset        (reset),
    .tick_16x     (tick_16x),
    .rx_pin       (rx_pin),
    .parity_enable(parity_enable),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tick every 4 clk, so a bit period of 64 clk is 16 ticks.
  initial begin
    tick_16x = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick_16x = 1'b1;
      @(posedge clk);
      #1 tick_16x = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every strobe must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_data_ready: got rx_data %0h with no frame expected", rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
        chk("parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
        chk("frame_err", {31'd0, frame_err}, {31'd0, mon_e.ferr});
      end
    end
  end

  // Full frame; expectation comes from bit counts, not from receiver internals.
  task automatic send_frame(input logic [7:0] data, input logic pe, input logic good_par,
                            input logic stop, input logic flip_pe);
    logic par_bit;
    exp_t e;
    par_bit = ($countones(data) % 2 == 1) ^ ~good_par;
    e.data  = data;
    e.perr  = pe && (($countones(data) + int'(par_bit)) % 2 == 1);
    e.ferr  = (stop == 1'b0);
    exp_q.push_back(e);
    last_data     = data;
    parity_enable = pe;
    rx_pin = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_pin = data[i];
      if (flip_pe && i == 3) parity_enable = ~pe;
      wait_clks(BIT_CLKS);
    end
    if (pe) begin
      rx_pin = par_bit;
      wait_clks(BIT_CLKS);
    end
    rx_pin = stop;
    wait_clks(BIT_CLKS);
    chk("frame_delivered_in_time", exp_q.size(), 32'd0);
  endtask

  task automatic idle(input int bits);
    rx_pin = 1'b1;
    wait_clks(bits * BIT_CLKS);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    chk({tag, "_data_ready"}, {31'd0, data_ready}, 32'd0);
    chk({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    rx_pin        = 1'b1;
    parity_enable = 1'b0;
    wait_clks(5);
    chk_zero_outputs("reset");
    reset = 1'b0;
    wait_clks(200);
    chk_zero_outputs("idle_after_reset");

    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("rx_data_hold", {24'd0, rx_data}, {24'd0, last_data});

    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("parity_err_hold", {31'd0, parity_err}, 32'd1);

    // Bad stop bit followed by a held-low line must yield one frame only.
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    rx_pin = 1'b0;
    wait_clks(3 * BIT_CLKS);
    idle(2);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);

    rx_pin = 1'b0;
    wait_clks(12);
    idle(2);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);

    // Abandon a frame halfway through data bit 4.
    parity_enable = 1'b0;
    rx_pin = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx_pin = i[0];
      wait_clks(BIT_CLKS);
    end
    rx_pin = 1'b1;
    wait_clks(BIT_CLKS / 2);
    reset = 1'b1;
    wait_clks(3);
    chk_zero_outputs("mid_frame_reset");
    reset = 1'b0;
    idle(2);
    chk_zero_outputs("after_abort");
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);

    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)));
      idle(1);
      chk("rx_data_hold_rand", {24'd0, rx_data}, {24'd0, last_data});
    end

    wait_clks(100);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
